// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor.
// Processes DIGIT bits of the operands per clock, least significant digit
// first. Subtraction adds the inverted subtrahend with the carry register
// seeded by ci^sub, so sub=1 gives a-b-ci and co=0 signals a borrow.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one digit added per clock, busy=1
//   DONE  | s/co/ov freshly loaded, done=1 for this cycle
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             busy,
    output logic             done
);

    localparam int N    = WIDTH / DIGIT;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_sum;
    logic             last_dig;
    logic             c_msb;

    // Digit slice of the current index and its sum with the running carry.
    // The carry into the top bit falls out of sum = a ^ b ^ carry_in, which
    // holds for any DIGIT including DIGIT=1.
    always_comb begin
        a_dig    = a_q[int'(idx_q)*DIGIT +: DIGIT];
        b_dig    = b_q[int'(idx_q)*DIGIT +: DIGIT] ^ {DIGIT{sub_q}};
        dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        last_dig = (idx_q == IDXW'(N - 1));
        c_msb    = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1];
    end

    // Next-state logic: operand capture, per-digit accumulation, result load.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = ci ^ sub;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[int'(idx_q)*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
                carry_d = dig_sum[DIGIT];
                if (last_dig) begin
                    s_d     = acc_d;
                    co_d    = dig_sum[DIGIT];
                    ov_d    = c_msb ^ dig_sum[DIGIT];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            idx_q   <= idx_d;
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: three configurations (16/4, 32/8,
// 8/8) driven together, fixed vectors, random regression against an
// arithmetic reference, back-to-back start and mid-run reset sequences.
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst;

    logic        start16, ci16, sub16;
    logic [15:0] a16, b16, s16;
    logic        co16, ov16, busy16, done16;

    logic        start32, ci32, sub32;
    logic [31:0] a32, b32, s32;
    logic        co32, ov32, busy32, done32;

    logic        start8, ci8, sub8;
    logic [7:0]  a8, b8, s8;
    logic        co8, ov8, busy8, done8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .ci(ci16),
        .sub(sub16), .s(s16), .co(co16), .ov(ov16), .busy(busy16), .done(done16));

    addsub_serial #(.WIDTH(32), .DIGIT(8)) u32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .ci(ci32),
        .sub(sub32), .s(s32), .co(co32), .ov(ov32), .busy(busy32), .done(done32));

    addsub_serial #(.WIDTH(8), .DIGIT(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .sub(sub8), .s(s8), .co(co8), .ov(ov8), .busy(busy8), .done(done8));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: result packed as {co, ov, s[31:0]}. co from the unsigned
    // sum's bit w, ov from whether the signed sum leaves the w-bit range.
    function automatic logic [33:0] model(input int w, input logic [31:0] va, input logic [31:0] vb,
                                          input logic vci, input logic vsub);
        longint unsigned mask, ua, ub, full;
        longint          sa, sb, r, half, cin;
        logic [33:0]     res;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, va} & mask;
        ub   = {32'd0, (vsub ? ~vb : vb)} & mask;
        cin  = (vci ^ vsub) ? 64'sd1 : 64'sd0;
        full = ua + ub + longint'(cin);
        half = 64'sd1 <<< (w - 1);
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (sa >= half) sa = sa - 2 * half;
        if (sb >= half) sb = sb - 2 * half;
        r    = sa + sb + cin;
        res[31:0] = full[31:0] & mask[31:0];
        res[33]   = full[w];
        res[32]   = (r >= half) || (r < -half);
        return res;
    endfunction

    // Launch one operation on all three instances and observe a fixed window.
    task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vci, input logic vsub,
                         output logic [33:0] r16, output logic [33:0] r32, output logic [33:0] r8);
        int nd16, nd32, nd8, nb16, nb32, nb8, at16, at32, at8;
        logic [15:0] hold16;
        logic [31:0] hold32;
        nd16 = 0; nd32 = 0; nd8 = 0; nb16 = 0; nb32 = 0; nb8 = 0;
        at16 = -1; at32 = -1; at8 = -1;
        r16 = '0; r32 = '0; r8 = '0;
        @(negedge clk);
        hold16 = s16;
        hold32 = s32;
        a16 = va[15:0]; b16 = vb[15:0]; ci16 = vci; sub16 = vsub; start16 = 1'b1;
        a32 = va;       b32 = vb;       ci32 = vci; sub32 = vsub; start32 = 1'b1;
        a8  = va[7:0];  b8  = vb[7:0];  ci8  = vci; sub8  = vsub; start8  = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0; start32 = 1'b0; start8 = 1'b0;
        a16 = ~a16; b16 = ~b16; a32 = ~a32; b32 = ~b32; a8 = ~a8; b8 = ~b8;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy16) begin
                nb16++;
                chk("s16_hold_in_run", {48'd0, s16}, {48'd0, hold16});
            end
            if (busy32) begin
                nb32++;
                chk("s32_hold_in_run", {32'd0, s32}, {32'd0, hold32});
            end
            if (busy8) nb8++;
            if (done16) begin nd16++; if (at16 < 0) at16 = k; r16 = {co16, ov16, 16'h0, s16}; end
            if (done32) begin nd32++; if (at32 < 0) at32 = k; r32 = {co32, ov32, s32}; end
            if (done8)  begin nd8++;  if (at8  < 0) at8  = k; r8  = {co8, ov8, 24'h0, s8}; end
        end
        chk("done16_count", 64'(nd16), 64'd1);
        chk("done32_count", 64'(nd32), 64'd1);
        chk("done8_count",  64'(nd8),  64'd1);
        chk("busy16_cycles", 64'(nb16), 64'd4);
        chk("busy32_cycles", 64'(nb32), 64'd4);
        chk("busy8_cycles",  64'(nb8),  64'd1);
        chk("done16_latency", 64'(at16), 64'd4);
        chk("done32_latency", 64'(at32), 64'd4);
        chk("done8_latency",  64'(at8),  64'd1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t        tbl[5];
    logic [33:0] r16, r32, r8;
    logic [31:0] ra, rb;
    logic        rci, rsub;
    logic [15:0] oa[26], ob[26];
    logic        oc[26], osb[26];
    int          ndone;

    initial begin
        tbl[0] = '{a:16'h1234, b:16'h0FF0, ci:1'b0, sub:1'b0, s:16'h2224, co:1'b0, ov:1'b0};
        tbl[1] = '{a:16'h0005, b:16'h0007, ci:1'b0, sub:1'b1, s:16'hFFFE, co:1'b0, ov:1'b0};
        tbl[2] = '{a:16'h0010, b:16'h0001, ci:1'b1, sub:1'b1, s:16'h000E, co:1'b1, ov:1'b0};
        tbl[3] = '{a:16'h7FFF, b:16'h0001, ci:1'b0, sub:1'b0, s:16'h8000, co:1'b0, ov:1'b1};
        tbl[4] = '{a:16'hFFFF, b:16'h0001, ci:1'b1, sub:1'b0, s:16'h0001, co:1'b1, ov:1'b0};

        rst = 1'b1;
        start16 = 0; a16 = '0; b16 = '0; ci16 = 0; sub16 = 0;
        start32 = 0; a32 = '0; b32 = '0; ci32 = 0; sub32 = 0;
        start8  = 0; a8  = '0; b8  = '0; ci8  = 0; sub8  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_u16", {s16, co16, ov16, busy16, done16}, '0);
        chk("reset_u32", {s32, co32, ov32, busy32, done32}, '0);
        chk("reset_u8",  {s8, co8, ov8, busy8, done8}, '0);
        rst = 1'b0;

        // Fixed vectors
        for (int i = 0; i < 5; i++) begin
            do_op({16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].ci, tbl[i].sub, r16, r32, r8);
            chk($sformatf("vec%0d_u16", i), r16, {tbl[i].co, tbl[i].ov, 16'h0, tbl[i].s});
            chk($sformatf("vec%0d_u8", i), r8,
                model(8, {16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].ci, tbl[i].sub));
        end

        // Random regression on all three configurations
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 8 == 0) ra = 32'h7FFF_FFFF;
            if (i % 8 == 1) rb = 32'h8000_0080;
            rci  = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            do_op(ra, rb, rci, rsub, r16, r32, r8);
            chk("rand_u16", r16, model(16, ra, rb, rci, rsub));
            chk("rand_u32", r32, model(32, ra, rb, rci, rsub));
            chk("rand_u8",  r8,  model(8,  ra, rb, rci, rsub));
        end

        // start held high: accepted only in IDLE/DONE, one result every 5 cycles
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (c > 0) begin
                chk("b2b_done", {63'd0, done16}, {63'd0, (c % 5 == 0)});
                if (c % 5 == 0)
                    chk("b2b_result", {co16, ov16, 16'h0, s16},
                        model(16, {16'h0, oa[c-5]}, {16'h0, ob[c-5]}, oc[c-5], osb[c-5]));
            end
            oa[c]  = 16'($urandom);
            ob[c]  = 16'($urandom);
            oc[c]  = 1'($urandom_range(0, 1));
            osb[c] = 1'($urandom_range(0, 1));
            a16 = oa[c]; b16 = ob[c]; ci16 = oc[c]; sub16 = osb[c];
            start16 = (c <= 20);
        end
        start16 = 1'b0;

        // Reset in the second RUN cycle aborts without done
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        chk("abort_busy_before", {63'd0, busy16}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        start16 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start16 = 1'b0;
        chk("abort_busy", {63'd0, busy16}, 64'd0);
        chk("abort_done", {63'd0, done16}, 64'd0);
        chk("abort_result", {46'd0, co16, ov16, s16}, 64'd0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done16 || busy16) ndone++;
        end
        chk("abort_no_activity", 64'(ndone), 64'd0);

        // Normal operation resumes after the abort
        do_op(32'h0000_4321, 32'h0000_1234, 1'b1, 1'b1, r16, r32, r8);
        chk("after_abort_u16", r16, {1'b1, 1'b0, 16'h0, 16'h30EC});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
